wdt_reset_escalator: RTL and testbench

- Downstream stage of the windowed watchdog peripheral; consumes its expiry signal and escalates in two steps.
- Step 1: raises an interrupt and starts a software grace period.
- Step 2: if software does not acknowledge in time, drives a timed active-low system reset pulse.
- Sits on the TinyQV peripheral bus. Configuration, acknowledge and status are register-mapped.

---
 rtl/wdt_reset_escalator.sv | 162 ++++++++++++++++
 tb/tb_wdt_reset_escalator.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wdt_reset_escalator.sv
// Two-step watchdog escalation: interrupt plus grace period, then a timed active-low reset pulse.
// Optional build macro WDT_ESC_ACK_KEY_EN: an ACK write must carry key 8'hA5 in data_in[7:0].
module wdt_reset_escalator #(
  parameter logic [31:0] GRACE_RST = 32'd1024,
  parameter logic [7:0]  PULSE_RST = 8'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wdt_expired,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt,
  output logic        sys_reset_n,
  output logic [7:0]  uo_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN  = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        enable;
  logic [31:0] grace;
  logic [7:0]  pulse_len;
  logic [31:0] cnt, cnt_nx;
  logic [7:0]  esc_count, esc_nx;
  logic [7:0]  ack_count, ack_nx;
  logic        exp_q;
  logic        wr, rise, ack_valid, dis_wr;
  logic [31:0] pulse_load;
  logic        unused;

  assign wr     = (data_write_n != 2'b11);
  assign rise   = wdt_expired & ~exp_q;
  assign dis_wr = wr && (address == 6'h0) && !data_in[0];
  assign unused = &{1'b0, data_read_n};

`ifdef WDT_ESC_ACK_KEY_EN
  assign ack_valid = wr && (address == 6'h3) && (data_in[7:0] == 8'hA5);
`else
  assign ack_valid = wr && (address == 6'h3);
`endif

  // A zero length still yields a one-cycle pulse.
  assign pulse_load = (pulse_len == 8'd0) ? 32'd0 : ({24'd0, pulse_len} - 32'd1);

  // Configuration registers; GRACE and PULSE_LEN are locked while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      grace     <= GRACE_RST;
      pulse_len <= PULSE_RST;
      exp_q     <= 1'b0;
    end else begin
      exp_q <= wdt_expired;
      if (wr && (address == 6'h0)) begin
        enable <= data_in[0];
      end else begin
        enable <= enable;
      end
      if (wr && (address == 6'h1) && !enable) begin
        grace <= data_in;
      end else begin
        grace <= grace;
      end
      if (wr && (address == 6'h2) && !enable) begin
        pulse_len <= data_in[7:0];
      end else begin
        pulse_len <= pulse_len;
      end
    end
  end

  // Escalation state, shared counter and event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      esc_count <= 8'd0;
      ack_count <= 8'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      esc_count <= esc_nx;
      ack_count <= ack_nx;
    end
  end

  // Next-state logic; ACK beats both disable and grace expiry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    esc_nx   = esc_count;
    ack_nx   = ack_count;
    case (state)
      IDLE: begin
        if (enable && rise) begin
          state_nx = WARN;
          cnt_nx   = grace;
        end else begin
          state_nx = IDLE;
        end
      end
      WARN: begin
        if (ack_valid) begin
          state_nx = IDLE;
          ack_nx   = (ack_count == 8'hFF) ? ack_count : ack_count + 8'd1;
        end else if (dis_wr) begin
          state_nx = IDLE;
        end else if (cnt == 32'd0) begin
          state_nx = PULSE;
          cnt_nx   = pulse_load;
          esc_nx   = (esc_count == 8'hFF) ? esc_count : esc_count + 8'd1;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      PULSE: begin
        if (cnt == 32'd0) begin
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - 32'd1;
        end
      end
      HOLD: begin
        if (!wdt_expired) begin
          state_nx = IDLE;
        end else begin
          state_nx = HOLD;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Register read mux.
  always_comb begin
    data_out = 32'd0;
    case (address)
      6'h0:    data_out = {31'd0, enable};
      6'h1:    data_out = grace;
      6'h2:    data_out = {24'd0, pulse_len};
      6'h4:    data_out = {8'd0, ack_count, esc_count, 5'd0, 1'b0, state};
      default: data_out = 32'd0;
    endcase
  end

  assign data_ready     = 1'b1;
  assign user_interrupt = (state == WARN);
  assign sys_reset_n    = (state != PULSE);
  assign uo_out         = {user_interrupt, ~sys_reset_n, 1'b0, state, enable, wdt_expired, 1'b0};

endmodule

// File: tb/tb_wdt_reset_escalator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle-count model.
module tb_wdt_reset_escalator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wdt_expired = 1'b0;
  logic [5:0]  address = 6'h4;
  logic [31:0] data_in = 32'd0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready, user_interrupt, sys_reset_n;
  logic [7:0]  uo_out;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  int irq_cnt = 0;
  int rst_cnt = 0;

  wdt_reset_escalator dut (
    .clk(clk), .rst_n(rst_n), .wdt_expired(wdt_expired), .address(address),
    .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt),
    .sys_reset_n(sys_reset_n), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  // Model: phase plus "cycles left in this phase", derived from the documented durations.
  typedef struct packed {
    logic        en;
    logic [31:0] grace;
    logic [7:0]  plen;
    logic [1:0]  phase;
    logic [32:0] left;
    logic [7:0]  esc;
    logic [7:0]  ack;
    logic        expq;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    r.grace = 32'd1024;
    r.plen  = 8'd16;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input logic e, input logic [5:0] a,
                                        input logic [31:0] d, input logic [1:0] wn);
    model_t n;
    logic w, ackv, dis;
    n = c;
    w = (wn != 2'b11);
`ifdef WDT_ESC_ACK_KEY_EN
    ackv = w && a == 6'd3 && d[7:0] == 8'hA5;
`else
    ackv = w && a == 6'd3;
`endif
    dis = w && a == 6'd0 && d[0] == 1'b0;
    if (c.phase == 2'd0 && c.en && e && !c.expq) begin
      n.phase = 2'd1;
      n.left  = {1'b0, c.grace} + 33'd1;
    end else if (c.phase == 2'd1) begin
      if (ackv) begin
        n.phase = 2'd0;
        if (c.ack != 8'd255) n.ack = c.ack + 8'd1;
      end else if (dis) begin
        n.phase = 2'd0;
      end else if (c.left == 33'd1) begin
        n.phase = 2'd2;
        n.left  = (c.plen == 8'd0) ? 33'd1 : {25'd0, c.plen};
        if (c.esc != 8'd255) n.esc = c.esc + 8'd1;
      end else begin
        n.left = c.left - 33'd1;
      end
    end else if (c.phase == 2'd2) begin
      if (c.left == 33'd1) n.phase = 2'd3;
      else n.left = c.left - 33'd1;
    end else if (c.phase == 2'd3 && !e) begin
      n.phase = 2'd0;
    end
    if (w && a == 6'd0) n.en = d[0];
    if (w && a == 6'd1 && !c.en) n.grace = d;
    if (w && a == 6'd2 && !c.en) n.plen = d[7:0];
    n.expq = e;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input model_t c, input logic [5:0] a);
    case (a)
      6'd0: return {31'd0, c.en};
      6'd1: return c.grace;
      6'd2: return {24'd0, c.plen};
      6'd4: return {8'd0, c.ack, c.esc, 6'd0, c.phase};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else m <= model_step(m, wdt_expired, address, data_in, data_write_n);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("user_interrupt", {31'd0, user_interrupt}, {31'd0, m.phase == 2'd1});
      check("sys_reset_n", {31'd0, sys_reset_n}, {31'd0, m.phase != 2'd2});
      check("uo_out", {24'd0, uo_out},
            {24'd0, m.phase == 2'd1, m.phase == 2'd2, 1'b0, m.phase, m.en, wdt_expired, 1'b0});
      check("data_out", data_out, model_read(m, address));
      check("data_ready", {31'd0, data_ready}, 32'd1);
    end
  end

  always @(negedge clk) begin
    irq_cnt <= irq_cnt + (user_interrupt ? 1 : 0);
    rst_cnt <= rst_cnt + (sys_reset_n ? 0 : 1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    data_write_n = 2'b00;
    cyc(1);
    data_write_n = 2'b11;
    address = 6'h4;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wdt_expired = 1'b0;
    data_write_n = 2'b11;
    address = 6'h4;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic setup(input logic [31:0] g, input logic [7:0] p);
    do_reset();
    wr(6'h1, g);
    wr(6'h2, {24'd0, p});
    wr(6'h0, 32'd1);
  endtask

  initial begin
    int bi, br, r;
    cyc(1);
    do_reset();
    chk_en = 1'b1;
    check("reset_status", data_out, 32'd0);
    check("reset_sysrst", {31'd0, sys_reset_n}, 32'd1);

    // Basic escalation: 5 interrupt cycles, 3 pulse cycles, HOLD while expired.
    setup(32'd4, 8'd3);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(20);
    check("s1_irq_cycles", irq_cnt - bi, 32'd5);
    check("s1_pulse_cycles", rst_cnt - br, 32'd3);
    check("s1_status_hold", data_out, {8'd0, 8'd0, 8'd1, 8'd3});
    wdt_expired = 1'b0;
    cyc(2);
    check("s1_status_idle", data_out, {8'd0, 8'd0, 8'd1, 8'd0});

    // ACK three cycles into WARN.
    setup(32'd10, 8'd3);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(1); cyc(2);
    wr(6'h3, 32'hA5);
    cyc(20);
    check("s2_irq_cycles", irq_cnt - bi, 32'd3);
    check("s2_pulse_cycles", rst_cnt - br, 32'd0);
    check("s2_status", data_out, {8'd0, 8'd1, 8'd0, 8'd0});

    // GRACE=0: ACK in the only WARN cycle wins; without ACK a default-length pulse follows.
    setup(32'd0, 8'd16);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(1);
    wr(6'h3, 32'hA5);
    cyc(5);
    check("s3_ack_irq", irq_cnt - bi, 32'd1);
    check("s3_ack_pulse", rst_cnt - br, 32'd0);
    wdt_expired = 1'b0;
    cyc(2);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(30);
    check("s3_noack_irq", irq_cnt - bi, 32'd1);
    check("s3_noack_pulse", rst_cnt - br, 32'd16);

    // PULSE_LEN=0 gives a one-cycle pulse.
    setup(32'd2, 8'd0);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(15);
    check("s4_irq", irq_cnt - bi, 32'd3);
    check("s4_pulse", rst_cnt - br, 32'd1);

    // Config lock.
    do_reset();
    wr(6'h0, 32'd1);
    wr(6'h1, 32'd99);
    address = 6'h1; #1;
    check("lock_grace", data_out, 32'd1024);
    wr(6'h0, 32'd0);
    wr(6'h1, 32'd99);
    address = 6'h1; #1;
    check("unlock_grace", data_out, 32'd99);
    address = 6'h4;

    // Disable mid-WARN.
    setup(32'd10, 8'd3);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(1); cyc(2);
    wr(6'h0, 32'd0);
    check("dis_warn_irq_now", {31'd0, user_interrupt}, 32'd0);
    cyc(20);
    check("dis_warn_irq", irq_cnt - bi, 32'd3);
    check("dis_warn_pulse", rst_cnt - br, 32'd0);

    // Disable mid-PULSE: pulse still full length.
    setup(32'd1, 8'd5);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(1); cyc(3);
    wr(6'h0, 32'd0);
    cyc(10);
    check("dis_pulse_len", rst_cnt - br, 32'd5);
    check("dis_pulse_irq", irq_cnt - bi, 32'd2);

    // Async reset mid-PULSE.
    setup(32'd0, 8'd8);
    wdt_expired = 1'b1;
    cyc(1); cyc(2);
    check("rst_mid_pulse_low", {31'd0, sys_reset_n}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_pulse_high", {31'd0, sys_reset_n}, 32'd1);
    check("rst_status", data_out, 32'd0);
    address = 6'h1; #1;
    check("rst_grace", data_out, 32'd1024);
    address = 6'h2; #1;
    check("rst_plen", data_out, 32'd16);
    address = 6'h0; #1;
    check("rst_ctrl", data_out, 32'd0);
    address = 6'h4;
    wdt_expired = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

`ifdef WDT_ESC_ACK_KEY_EN
    // Wrong key is ignored.
    setup(32'd2, 8'd2);
    bi = irq_cnt; br = rst_cnt;
    wdt_expired = 1'b1;
    cyc(1);
    wr(6'h3, 32'h00);
    cyc(15);
    check("key_bad_pulse", rst_cnt - br, 32'd2);
    check("key_bad_irq", irq_cnt - bi, 32'd3);
`endif

    // Randomized traffic.
    setup(32'd3, 8'd2);
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if ($urandom_range(0, 99) < 8) wdt_expired = ~wdt_expired;
      address = 6'($urandom_range(0, 63));
      data_in = $urandom;
      data_write_n = 2'b11;
      if (r < 3) begin
        rst_n = 1'b0;
      end else if (r < 40) begin
        address = 6'h0;
        data_in[0] = ($urandom_range(0, 9) < 7);
        data_write_n = 2'($urandom_range(0, 2));
      end else if (r < 70) begin
        address = 6'h1;
        data_in = 32'($urandom_range(0, 12));
        data_write_n = 2'($urandom_range(0, 2));
      end else if (r < 100) begin
        address = 6'h2;
        data_in[7:0] = 8'($urandom_range(0, 6));
        data_write_n = 2'($urandom_range(0, 2));
      end else if (r < 160) begin
        address = 6'h3;
        if ($urandom_range(0, 1) == 1) data_in[7:0] = 8'hA5;
        data_write_n = 2'($urandom_range(0, 2));
      end else if (r < 175) begin
        address = 6'($urandom_range(5, 63));
        data_write_n = 2'($urandom_range(0, 2));
      end
      cyc(1);
      rst_n = 1'b1;
    end
    data_write_n = 2'b11;
    cyc(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
